// File: rtl/conv_pkg.sv
// Shared width defaults and arithmetic helpers for the convolution MAC pipeline.
package conv_pkg;

  localparam int unsigned IN_CH_DEF    = 3;
  localparam int unsigned K_DEF        = 5;
  localparam int unsigned DATA_W_DEF   = 12;
  localparam int unsigned WEIGHT_W_DEF = 8;
  localparam int unsigned ACC_W_DEF    = 24;
  localparam int unsigned SHIFT_DEF    = 6;
  localparam int unsigned OUT_W_DEF    = 14;

  localparam int unsigned KK   = K_DEF * K_DEF;
  localparam int unsigned NTAP = IN_CH_DEF * KK;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

  // Floor shift, optional ReLU, then clamp into a signed out_w-bit range.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int unsigned shift,
                                                   input int unsigned out_w,
                                                   input bit relu_en);
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s  = acc >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (relu_en && (s < 64'sd0)) s = 64'sd0;
    if (s > hi) s = hi;
    else if (s < lo) s = lo;
    return s;
  endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Combinational sum of N packed two's-complement values of W bits each.
module conv_adder_tree #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 8
) (
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   sum
);

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < N; i++) sum = sum + din[i*W +: W];
  end

endmodule

// File: rtl/conv_mac_pipe.sv
// Four-stage multi-channel KxK convolution MAC with loadable weights/bias,
// scaled/saturated output and a pair strobe for the downstream 2x max-pool.
module conv_mac_pipe
  import conv_pkg::*;
#(
  parameter int unsigned IN_CH    = IN_CH_DEF,
  parameter int unsigned K        = K_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned WEIGHT_W = WEIGHT_W_DEF,
  parameter int unsigned ACC_W    = ACC_W_DEF,
  parameter int unsigned SHIFT    = SHIFT_DEF,
  parameter int unsigned OUT_W    = OUT_W_DEF,
  parameter bit          RELU_EN  = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  input  logic [IN_CH*K*K*DATA_W-1:0]       in_window,
  input  logic                              wt_we,
  input  logic [clog2(IN_CH*K*K+1)-1:0]     wt_addr,
  input  logic [ACC_W-1:0]                  wt_data,
  output logic                              out_valid,
  output logic [OUT_W-1:0]                  out_data,
  output logic                              out_pair,
  output logic                              busy
);

  localparam int unsigned TAPS  = K * K;
  localparam int unsigned NTAPS = IN_CH * TAPS;
  localparam int unsigned AW    = clog2(NTAPS + 1);
  localparam int unsigned PW    = DATA_W + WEIGHT_W;

  logic signed [WEIGHT_W-1:0]  wt   [NTAPS];
  logic signed [ACC_W-1:0]     bias;
  logic signed [DATA_W-1:0]    act  [NTAPS];
  logic signed [PW-1:0]        prod [NTAPS];
  logic [ACC_W-1:0]            ch_sum_c [IN_CH];
  logic [ACC_W-1:0]            ch_sum   [IN_CH];
  logic [(IN_CH+1)*ACC_W-1:0]  s3_in;
  logic [ACC_W-1:0]            total_c;
  logic signed [ACC_W-1:0]     acc;
  logic                        v1, v2, v3;
  logic                        phase;

  // Coefficient store survives reset; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (wt_we) begin
      if (wt_addr < AW'(NTAPS)) wt[wt_addr] <= wt_data[WEIGHT_W-1:0];
      else if (wt_addr == AW'(NTAPS)) bias <= wt_data;
    end
  end

  for (genvar i = 0; i < NTAPS; i++) begin : g_act
    assign act[i] = in_window[i*DATA_W +: DATA_W];
  end

  // S1: full-width signed products.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      for (int unsigned i = 0; i < NTAPS; i++) prod[i] <= PW'(act[i]) * PW'(wt[i]);
    end
  end

  // S2: per-channel tap sums, products sign-extended to the accumulator width.
  for (genvar c = 0; c < IN_CH; c++) begin : g_ch
    logic [TAPS*ACC_W-1:0] tin;
    for (genvar t = 0; t < TAPS; t++) begin : g_tap
      assign tin[t*ACC_W +: ACC_W] = ACC_W'(prod[c*TAPS+t]);
    end
    conv_adder_tree #(.N(TAPS), .W(ACC_W)) u_ch_tree (.din(tin), .sum(ch_sum_c[c]));
    assign s3_in[c*ACC_W +: ACC_W] = ch_sum[c];
  end

  always_ff @(posedge clk) begin
    if (v1) ch_sum <= ch_sum_c;
  end

  // S3: channels plus bias.
  assign s3_in[IN_CH*ACC_W +: ACC_W] = bias;

  conv_adder_tree #(.N(IN_CH+1), .W(ACC_W)) u_sum_tree (.din(s3_in), .sum(total_c));

  always_ff @(posedge clk) begin
    if (v2) acc <= total_c;
  end

  // S4 plus valid pipe; busy is registered as the OR of the next valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out_pair  <= 1'b0;
      out_data  <= '0;
      phase     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      out_pair  <= v3 & phase;
      busy      <= in_valid | v1 | v2 | v3;
      if (v3) begin
        phase    <= ~phase;
        out_data <= OUT_W'(sat_shift(64'(acc), SHIFT, OUT_W, RELU_EN));
      end
    end
  end

endmodule

// File: tb/tb_conv_mac_pipe.sv
// Directed bench for conv_mac_pipe: one plain instance and one with ReLU enabled.
module tb_conv_mac_pipe;

  localparam int unsigned IN_CH  = 3;
  localparam int unsigned KK     = 25;
  localparam int unsigned NTAP   = 75;
  localparam int unsigned DATA_W = 12;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned OUT_W  = 14;
  localparam int unsigned AW     = 7;

  logic                      clk;
  logic                      rst_n;
  logic                      in_valid;
  logic [NTAP*DATA_W-1:0]    in_window;
  logic                      wt_we;
  logic [AW-1:0]             wt_addr;
  logic [ACC_W-1:0]          wt_data;
  logic                      out_valid, out_pair, busy;
  logic signed [OUT_W-1:0]   out_data;
  logic                      r_valid, r_pair, r_busy;
  logic signed [OUT_W-1:0]   r_data;

  int n_chk;
  int n_err;

  conv_mac_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_window(in_window),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(out_valid), .out_data(out_data), .out_pair(out_pair), .busy(busy)
  );

  conv_mac_pipe #(.RELU_EN(1'b1)) u_relu (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_window(in_window),
    .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
    .out_valid(r_valid), .out_data(r_data), .out_pair(r_pair), .busy(r_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    wt_we   = 1'b1;
    wt_addr = AW'(addr);
    wt_data = ACC_W'(data);
    tick();
    wt_we   = 1'b0;
  endtask

  task automatic fill_w(input int v);
    for (int a = 0; a < int'(NTAP); a++) wr(a, v);
  endtask

  task automatic set_tap(input int c, input int t, input int v);
    in_window[(c*KK+t)*DATA_W +: DATA_W] = DATA_W'(v);
  endtask

  // One window; lat counts clock edges from the edge that samples in_valid.
  task automatic send_one(output int lat, output int d, output int rd, output int p);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    d  = int'(out_data);
    rd = int'(r_data);
    p  = int'(out_pair);
  endtask

  int lat, d, rd, p, ev, nout;
  int got [2];

  initial begin
    n_chk = 0; n_err = 0;
    rst_n = 1'b0; in_valid = 1'b0; wt_we = 1'b0; wt_addr = '0; wt_data = '0; in_window = '0;
    repeat (3) tick();
    check("rst_valid", int'(out_valid), 0);
    check("rst_data", int'(out_data), 0);
    check("rst_pair", int'(out_pair), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    tick();

    // Centre-tap identity: (10+20+30)*64 >>> 6 = 60
    fill_w(0); wr(75, 0);
    for (int c = 0; c < 3; c++) wr(c*25+12, 64);
    set_tap(0, 12, 10); set_tap(1, 12, 20); set_tap(2, 12, 30);
    send_one(lat, d, rd, p);
    check("id_lat", lat, 4);
    check("id_data", d, 60);
    check("id_relu", rd, 60);
    check("id_pair", p, 0);

    // Saturation both ways
    fill_w(127);
    for (int c = 0; c < 3; c++) for (int t = 0; t < 25; t++) set_tap(c, t, 2047);
    send_one(lat, d, rd, p);
    check("satp_data", d, 8191);
    check("satp_relu", rd, 8191);
    check("satp_pair", p, 1);
    fill_w(-127);
    send_one(lat, d, rd, p);
    check("satn_data", d, -8192);
    check("satn_relu", rd, 0);

    // Floor of -65/64 and ReLU clamp
    fill_w(0); wr(0, 1);
    in_window = '0; set_tap(0, 0, -65);
    send_one(lat, d, rd, p);
    check("floor_data", d, -2);
    check("floor_relu", rd, 0);

    // Bias only, six back-to-back windows after a fresh reset
    wr(0, 0); wr(75, 640); in_window = '0;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      in_valid = (cyc < 6);
      tick();
      ev = (cyc >= 3 && cyc <= 8) ? 1 : 0;
      check("bp_valid", int'(out_valid), ev);
      if (ev == 1) begin
        check("bp_data", int'(out_data), 10);
        check("bp_pair", int'(out_pair), (cyc - 3) % 2);
      end
      check("bp_busy", int'(busy), (cyc <= 8) ? 1 : 0);
    end
    in_valid = 1'b0;

    // Reset during the second output cycle of three in flight
    wr(75, 0);
    for (int c = 0; c < 3; c++) wr(c*25+12, 64);
    set_tap(0, 12, 10); set_tap(1, 12, 20); set_tap(2, 12, 30);
    for (int cyc = 0; cyc < 10; cyc++) begin
      in_valid = (cyc < 3);
      rst_n    = (cyc != 4);
      tick();
      check("rm_valid", int'(out_valid), (cyc == 3) ? 1 : 0);
      if (cyc == 3) begin
        check("rm_data", int'(out_data), 60);
        check("rm_pair", int'(out_pair), 0);
      end
      if (cyc >= 4) check("rm_busy", int'(busy), 0);
    end
    in_valid = 1'b0; rst_n = 1'b1;
    send_one(lat, d, rd, p);
    check("rm_lat", lat, 4);
    check("rm_wts", d, 60);
    check("rm_pair2", p, 0);

    // Weight write hazard: first window sees 5, second sees 9
    fill_w(0);
    in_window = '0; set_tap(0, 0, 64);
    wt_we = 1'b1; wt_addr = '0; wt_data = ACC_W'(5);
    tick();
    in_valid = 1'b1; wt_data = ACC_W'(9);
    tick();
    wt_we = 1'b0;
    tick();
    in_valid = 1'b0;
    nout = 0; got[0] = -1; got[1] = -1;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (out_valid) begin
        if (nout < 2) got[nout] = int'(out_data);
        nout++;
      end
    end
    check("wh_count", nout, 2);
    check("wh_first", got[0], 5);
    check("wh_second", got[1], 9);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
